// File: rtl/if_fetch_queue.sv
// Pipelined instruction fetch front-end: issues up to MAX_OUTSTANDING imem requests and buffers returned words in an in-order queue.
// Optional IF_FETCH_PERF_EN adds saturating pop/discard counters.
module if_fetch_queue #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned     FQ_DEPTH        = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_discarded_o
`endif
);

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] fq_inst_q [FQ_DEPTH];
  logic [XLEN-1:0] fq_inst_d [FQ_DEPTH];
  logic [XLEN-1:0] fq_pc_q [FQ_DEPTH];
  logic [XLEN-1:0] fq_pc_d [FQ_DEPTH];
  logic [XLEN-1:0] pcf_q [MAX_OUTSTANDING];
  logic [XLEN-1:0] pcf_d [MAX_OUTSTANDING];
  logic [FW-1:0]   pcf_rd_q, pcf_rd_d;
  logic [FW-1:0]   pcf_wr_q, pcf_wr_d;

  logic [OW-1:0] live;
  logic [SW-1:0] credit_used;
  logic          grant;
  logic          drop;
  logic          push;
  logic          pop;
  logic          unused_redirect_lsbs;

  function automatic logic [FW-1:0] pcf_next(input logic [FW-1:0] p);
    if (p == FW'(MAX_OUTSTANDING - 1)) return '0;
    return p + FW'(1);
  endfunction

  // Every live request owns a queue slot, so a response can always be pushed.
  assign live        = outstanding_q - discard_q;
  assign credit_used = SW'(count_q) + SW'(live);
  assign imem_req_o  = !rst && !redirect_i && (outstanding_q < OW'(MAX_OUTSTANDING))
                       && (credit_used < SW'(FQ_DEPTH));
  assign imem_addr_o = fetch_pc_q;

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = fq_inst_q[rd_ptr_q];
  assign pc_o         = fq_pc_q[rd_ptr_q];

  assign grant = imem_req_o && imem_gnt_i;
  assign drop  = imem_rvalid_i && (redirect_i || (discard_q != '0));
  assign push  = imem_rvalid_i && !drop;
  assign pop   = inst_valid_o && inst_ready_i && !redirect_i;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + OW'(grant) - OW'(imem_rvalid_i);
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fq_inst_d     = fq_inst_q;
    fq_pc_d       = fq_pc_q;
    pcf_d         = pcf_q;
    pcf_rd_d      = pcf_rd_q;
    pcf_wr_d      = pcf_wr_q;

    if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      discard_d  = outstanding_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      pcf_rd_d   = '0;
      pcf_wr_d   = '0;
    end else begin
      if (grant) begin
        fetch_pc_d      = fetch_pc_q + XLEN'(4);
        pcf_d[pcf_wr_q] = fetch_pc_q;
        pcf_wr_d        = pcf_next(pcf_wr_q);
      end
      if (drop) discard_d = discard_q - OW'(1);
      if (push) begin
        fq_inst_d[wr_ptr_q] = imem_rdata_i;
        fq_pc_d[wr_ptr_q]   = pcf_q[pcf_rd_q];
        wr_ptr_d            = wr_ptr_q + PW'(1);
        pcf_rd_d            = pcf_next(pcf_rd_q);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      pcf_rd_q      <= '0;
      pcf_wr_q      <= '0;
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        fq_inst_q[i] <= '0;
        fq_pc_q[i]   <= RESET_PC;
      end
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) pcf_q[i] <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pcf_rd_q      <= pcf_rd_d;
      pcf_wr_q      <= pcf_wr_d;
      fq_inst_q     <= fq_inst_d;
      fq_pc_q       <= fq_pc_d;
      pcf_q         <= pcf_d;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_discarded_q, perf_discarded_d;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  // A flush discards the buffered entries as well as any word dropped this cycle.
  always_comb begin
    perf_fetched_d   = sat_add(perf_fetched_q, 32'(pop));
    perf_discarded_d = sat_add(perf_discarded_q,
                               (redirect_i ? 32'(count_q) : 32'd0) + 32'(drop));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_discarded_q <= perf_discarded_d;
    end
  end

  assign perf_fetched_o   = perf_fetched_q;
  assign perf_discarded_o = perf_discarded_q;
`endif

endmodule
